dogbattle_turn_ctrl: RTL and testbench
======================================

Name: dogbattle_turn_ctrl

Overview:
Turn scheduler for the dogbattle datapath. Two players share one 8-bit adder/subtractor that applies attacks to hit points. The block arbitrates attack requests round-robin, sequences each attack through the shared datapath, tracks both HP values and the turn count, and declares a winner at KO. It sits between the pin-level input decode and the uo_out display logic.

Parameters:
HP_INIT, 8'd100, HP loaded into both players on start
W, 8, datapath width for HP and attack values

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; (re)loads HP and begins a battle
req_a  in  1  player A attack request; held until gnt_a
atk_a  in  W  player A attack value
req_b  in  1  player B attack request; held until gnt_b
atk_b  in  W  player B attack value
gnt_a  out  1  one-cycle grant to A; atk_a captured on this edge
gnt_b  out  1  one-cycle grant to B; atk_b captured on this edge
hp_a  out  W  player A current HP
hp_b  out  W  player B current HP
turn_cnt  out  8  attacks applied this battle; saturates at 255
busy  out  1  high in GRANT or APPLY
winner  out  2  00 none, 01 A, 10 B
ko  out  1  high while in OVER

Behaviour:
- Reset, asynchronous: state=IDLE, all outputs 0, hp_a=hp_b=0, rr pointer=A (A wins the first tie).
- FSM states: IDLE, ARB, GRANT, APPLY, OVER.
- IDLE: wait for start.
- start in any state: next state ARB; hp_a=hp_b=HP_INIT; turn_cnt=0; winner=00; ko=0; rr pointer=A. An in-flight attack is discarded. start has priority over every other event.
- ARB: if no req, stay in ARB. If one req, grant that player. If both req, grant the player not served last.
  - Transition to GRANT on the same edge.
  - gnt_x is registered and is high only during GRANT (exactly 1 cycle).
  - atk_x is latched on that edge; attacker and target are recorded.
- GRANT -> APPLY, unconditional.
  - Shared (W+1)-bit subtractor computes target_hp - atk.
  - Borrow, or result 0, means the target HP becomes 0 (saturating).
- APPLY: register the new target HP and increment turn_cnt (saturate at 255). Update the rr pointer to the attacker.
  - If new target HP==0: go to OVER; winner=attacker; ko=1.
  - Otherwise go back to ARB.
- Latency: req sampled at ARB edge N; gnt high in cycle N+1; hp updated at edge N+2; next ARB in cycle N+2.
- atk=0 is legal: counts as a turn, HP unchanged.
- A player with HP already 0 cannot occur outside OVER.
- OVER: hold hp, winner, ko, turn_cnt. Ignore requests and drive no grants. Leave only on start or rst.
- A req dropped before grant is simply not served. No grant is ever issued while in IDLE or OVER.
- Only one subtractor exists; its operands are muxed by the recorded attacker. Never instantiate two.

Decomposition:
- Package dogbattle_pkg:
  - state enum (IDLE, ARB, GRANT, APPLY, OVER)
  - winner codes (WIN_NONE=2'b00, WIN_A=2'b01, WIN_B=2'b10)
  - W and HP_INIT defaults
- Sub-module dogbattle_rr_arb: 2-way round-robin.
  - Inputs: req_a, req_b, last_served.
  - Outputs: sel, valid.
  - Combinational, with the pointer register kept in the parent.

Test Plan:
- Reset mid-APPLY (rst high 1 cycle) -> all outputs 0 and state IDLE immediately, asynchronously; a later start loads hp_a=hp_b=100.
- start; req_a with atk_a=30 -> gnt_a high 1 cycle, one cycle after req is seen; next cycle hp_b=70, turn_cnt=1, busy low afterwards.
- req_a and req_b held together, atk=10 each, 4 turns -> grant order A, B, A, B; hp_a=80, hp_b=80, turn_cnt=4.
- hp_b=70, then A attacks with atk_a=200 -> hp_b=0 (no wrap to a large value), winner=01, ko=1; further reqs get no gnt.
- In OVER, pulse start -> hp_a=hp_b=100, winner=00, ko=0, turn_cnt=0; ARB resumes with A favored on a tie.
- start pulsed in the GRANT cycle of a B attack (atk_b=50) -> attack discarded; hp_a=100, turn_cnt=0.

Source files
------------

// File: rtl/dogbattle_pkg.sv
// Shared types and defaults for the dogbattle turn controller.
//   state_t  : turn-sequencing FSM states
//   winner_t : winner codes as driven on the winner output
//   player_t : identifies a player (attacker, arbiter select, last served)
package dogbattle_pkg;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned HP_INIT_DEF = 100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    GRANT = 3'd2,
    APPLY = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10
  } winner_t;

  typedef enum logic {
    PL_A = 1'b0,
    PL_B = 1'b1
  } player_t;

endpackage

// File: rtl/dogbattle_rr_arb.sv
// Two-way round-robin arbiter, purely combinational.
//   req_a, req_b : attack requests
//   last_served  : player granted most recently (pointer lives in the parent)
//   sel          : chosen player (meaningful only when valid)
//   valid        : at least one request present
module dogbattle_rr_arb
  import dogbattle_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  player_t last_served,
  output player_t sel,
  output logic    valid
);

  always_comb begin
    valid = req_a | req_b;
    // On a tie the player not served last wins.
    if (req_a && req_b) begin
      sel = (last_served == PL_A) ? PL_B : PL_A;
    end else if (req_b) begin
      sel = PL_B;
    end else begin
      sel = PL_A;
    end
  end

endmodule

// File: rtl/dogbattle_turn_ctrl.sv
// Turn scheduler for the dogbattle datapath. Arbitrates attack requests
// round-robin, runs each attack through one shared saturating subtractor,
// tracks both HP values and the turn count, and declares the winner at KO.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : pulse, (re)loads HP and begins a battle (top priority)
//   req_x / atk_x     : attack request (held until gnt_x) and attack value
//   gnt_x             : one-cycle grant, atk_x captured on the same edge
//   hp_a, hp_b        : current hit points
//   turn_cnt          : attacks applied this battle, saturating at 255
//   busy              : attack in flight (GRANT or APPLY)
//   winner, ko        : winner code and KO flag (ko high while in OVER)
module dogbattle_turn_ctrl
  import dogbattle_pkg::*;
#(
  parameter int unsigned    W       = W_DEF,
  parameter logic [W-1:0]   HP_INIT = W'(HP_INIT_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         req_a,
  input  logic [W-1:0] atk_a,
  input  logic         req_b,
  input  logic [W-1:0] atk_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic [W-1:0] hp_a,
  output logic [W-1:0] hp_b,
  output logic [7:0]   turn_cnt,
  output logic         busy,
  output logic [1:0]   winner,
  output logic         ko
);

  state_t       r_state;
  state_t       w_next_state;
  logic [W-1:0] r_hp_a;
  logic [W-1:0] r_hp_b;
  logic [W-1:0] r_atk;
  player_t      r_attacker;
  // Holds the player served last; resetting it to B makes A win the first tie.
  player_t      r_last_served;
  logic [7:0]   r_turn_cnt;
  winner_t      r_winner;
  logic         r_gnt_a;
  logic         r_gnt_b;

  player_t      w_arb_sel;
  logic         w_arb_valid;
  logic         w_grant_a;
  logic         w_grant_b;
  logic [W-1:0] w_tgt_hp;
  logic [W:0]   w_sub;
  logic [W-1:0] w_new_hp;
  logic         w_ko_hit;

  dogbattle_rr_arb u_arb (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_served (r_last_served),
    .sel         (w_arb_sel),
    .valid       (w_arb_valid)
  );

  // Single subtractor; the recorded attacker selects which HP is the target.
  // The extra MSB is the borrow, which clamps the result to 0.
  assign w_tgt_hp = (r_attacker == PL_A) ? r_hp_b : r_hp_a;
  assign w_sub    = {1'b0, w_tgt_hp} - {1'b0, r_atk};
  assign w_new_hp = w_sub[W] ? '0 : w_sub[W-1:0];
  assign w_ko_hit = (w_new_hp == '0);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    if (start) begin
      w_next_state = ARB;
    end else begin
      case (r_state)
        IDLE:  w_next_state = IDLE;
        ARB: begin
          if (w_arb_valid) begin
            w_next_state = GRANT;
            w_grant_a    = (w_arb_sel == PL_A);
            w_grant_b    = (w_arb_sel == PL_B);
          end
        end
        GRANT: w_next_state = APPLY;
        APPLY: w_next_state = w_ko_hit ? OVER : ARB;
        OVER:  w_next_state = OVER;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: this block holds only small control/datapath registers (no memory
  // arrays), so all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hp_a        <= '0;
      r_hp_b        <= '0;
      r_atk         <= '0;
      r_attacker    <= PL_A;
      r_last_served <= PL_B;
      r_turn_cnt    <= '0;
      r_winner      <= WIN_NONE;
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
    end else begin
      r_gnt_a <= w_grant_a;
      r_gnt_b <= w_grant_b;
      if (start) begin
        // Any in-flight attack is dropped: APPLY is never reached for it.
        r_hp_a        <= HP_INIT;
        r_hp_b        <= HP_INIT;
        r_turn_cnt    <= '0;
        r_winner      <= WIN_NONE;
        r_last_served <= PL_B;
      end else begin
        if (w_grant_a || w_grant_b) begin
          r_atk      <= w_grant_a ? atk_a : atk_b;
          r_attacker <= w_arb_sel;
        end
        if (r_state == APPLY) begin
          if (r_attacker == PL_A) begin
            r_hp_b <= w_new_hp;
          end else begin
            r_hp_a <= w_new_hp;
          end
          if (r_turn_cnt != 8'hFF) begin
            r_turn_cnt <= r_turn_cnt + 8'd1;
          end
          r_last_served <= r_attacker;
          if (w_ko_hit) begin
            r_winner <= (r_attacker == PL_A) ? WIN_A : WIN_B;
          end
        end
      end
    end
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign hp_a     = r_hp_a;
  assign hp_b     = r_hp_b;
  assign turn_cnt = r_turn_cnt;
  assign busy     = (r_state == GRANT) || (r_state == APPLY);
  assign winner   = r_winner;
  assign ko       = (r_state == OVER);

endmodule

// File: tb/tb_dogbattle_turn_ctrl.sv
// Self-checking bench for dogbattle_turn_ctrl. A small HP/turn model pushes
// the expected outcome of each attack into a queue when the request is
// issued; the entry is popped and compared when the grant appears and the
// attack is applied.
module tb_dogbattle_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] atk_a = '0;
  logic [7:0] atk_b = '0;
  logic       gnt_a;
  logic       gnt_b;
  logic [7:0] hp_a;
  logic [7:0] hp_b;
  logic [7:0] turn_cnt;
  logic       busy;
  logic [1:0] winner;
  logic       ko;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       b;      // 1: B is the attacker
    logic [7:0] hp_a;
    logic [7:0] hp_b;
    logic [7:0] turn;
    logic [1:0] win;
    logic       ko;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_hp_a, m_hp_b, m_turn;
  logic [1:0] m_win;
  logic       m_ko;

  dogbattle_turn_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .req_a    (req_a),
    .atk_a    (atk_a),
    .req_b    (req_b),
    .atk_b    (atk_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .hp_a     (hp_a),
    .hp_b     (hp_b),
    .turn_cnt (turn_cnt),
    .busy     (busy),
    .winner   (winner),
    .ko       (ko)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic model_start();
    m_hp_a = 8'd100;
    m_hp_b = 8'd100;
    m_turn = 8'd0;
    m_win  = 2'b00;
    m_ko   = 1'b0;
    sb.delete();
  endtask

  // Model one attack and queue its expected outcome.
  task automatic push_attack(input logic b, input logic [7:0] atk);
    exp_t e;
    if (b) begin
      if (atk >= m_hp_a) m_hp_a = 8'd0; else m_hp_a = m_hp_a - atk;
      if (m_hp_a == 8'd0) begin m_win = 2'b10; m_ko = 1'b1; end
    end else begin
      if (atk >= m_hp_b) m_hp_b = 8'd0; else m_hp_b = m_hp_b - atk;
      if (m_hp_b == 8'd0) begin m_win = 2'b01; m_ko = 1'b1; end
    end
    if (m_turn != 8'd255) m_turn = m_turn + 8'd1;
    e = '{b: b, hp_a: m_hp_a, hp_b: m_hp_b, turn: m_turn, win: m_win, ko: m_ko};
    sb.push_back(e);
  endtask

  // Called at a negedge; pulses start across one rising edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  // Wait (bounded) for a grant, pop the scoreboard and check the grant,
  // its one-cycle width, and the applied result.
  task automatic serve_one(input bit drop_after);
    exp_t e;
    int   n;
    n = 0;
    while (gnt_a !== 1'b1 && gnt_b !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20 || sb.size() == 0) begin
      failures++;
      $display("FAIL grant_wait: waited %0d cycles, queued entries %0d", n, sb.size());
      req_a = 1'b0;
      req_b = 1'b0;
      return;
    end
    e = sb.pop_front();
    if (drop_after) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    checks++;
    if ({gnt_b, gnt_a} !== (e.b ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL grant_who: got {gnt_b,gnt_a}=%b expected %b", {gnt_b, gnt_a}, (e.b ? 2'b10 : 2'b01));
    end
    @(negedge clk);
    checks++;
    if ({gnt_b, gnt_a, busy} !== 3'b001) begin
      failures++;
      $display("FAIL grant_pulse: got {gnt_b,gnt_a,busy}=%b expected 001", {gnt_b, gnt_a, busy});
    end
    @(negedge clk);
    checks++;
    if ({hp_a, hp_b, turn_cnt, winner, ko, busy} !== {e.hp_a, e.hp_b, e.turn, e.win, e.ko, 1'b0}) begin
      failures++;
      $display("FAIL apply_result: got hp_a=%0d hp_b=%0d turn=%0d win=%b ko=%b busy=%b expected hp_a=%0d hp_b=%0d turn=%0d win=%b ko=%b busy=0",
               hp_a, hp_b, turn_cnt, winner, ko, busy, e.hp_a, e.hp_b, e.turn, e.win, e.ko);
    end
  endtask

  task automatic check_idle_state(input string name, input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [7:0] et, input logic [1:0] ew, input logic ek);
    checks++;
    if ({hp_a, hp_b, turn_cnt, winner, ko, busy, gnt_a, gnt_b} !== {ea, eb, et, ew, ek, 3'b000}) begin
      failures++;
      $display("FAIL %s: got hp_a=%0d hp_b=%0d turn=%0d win=%b ko=%b busy=%b gnt=%b%b expected hp_a=%0d hp_b=%0d turn=%0d win=%b ko=%b busy=0 gnt=00",
               name, hp_a, hp_b, turn_cnt, winner, ko, busy, gnt_a, gnt_b, ea, eb, et, ew, ek);
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_state("reset_outputs", 8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_state("idle_after_reset", 8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
  endtask

  task automatic test_single_attack();
    do_start();
    check_idle_state("start_load", 8'd100, 8'd100, 8'd0, 2'b00, 1'b0);
    req_a = 1'b1;
    atk_a = 8'd30;
    push_attack(1'b0, 8'd30);
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL grant_latency: gnt_a=%b one cycle after req, expected 1", gnt_a);
    end
    serve_one(1'b1);
  endtask

  task automatic test_ko();
    bit seen;
    req_a = 1'b1;
    atk_a = 8'd200;
    push_attack(1'b0, 8'd200);
    serve_one(1'b1);
    req_a = 1'b1;
    req_b = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) seen = 1'b1;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL over_no_grant: grant observed in OVER, expected none");
    end
    check_idle_state("over_hold", 8'd100, 8'd0, 8'd2, 2'b01, 1'b1);
  endtask

  task automatic test_restart_from_over();
    do_start();
    check_idle_state("restart_load", 8'd100, 8'd100, 8'd0, 2'b00, 1'b0);
  endtask

  task automatic test_round_robin();
    atk_a = 8'd10;
    atk_b = 8'd10;
    req_a = 1'b1;
    req_b = 1'b1;
    push_attack(1'b0, 8'd10);
    push_attack(1'b1, 8'd10);
    push_attack(1'b0, 8'd10);
    push_attack(1'b1, 8'd10);
    serve_one(1'b0);
    serve_one(1'b0);
    serve_one(1'b0);
    serve_one(1'b1);
    check_idle_state("rr_final", 8'd80, 8'd80, 8'd4, 2'b00, 1'b0);
  endtask

  task automatic test_zero_attack();
    atk_b = 8'd0;
    req_b = 1'b1;
    push_attack(1'b1, 8'd0);
    serve_one(1'b1);
  endtask

  task automatic test_turn_saturate();
    atk_a = 8'd0;
    atk_b = 8'd0;
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 252; i++) push_attack(i[0], 8'd0);
    for (int i = 0; i < 252; i++) serve_one(i == 251);
    check_idle_state("turn_saturated", 8'd80, 8'd80, 8'd255, 2'b00, 1'b0);
  endtask

  task automatic test_start_discard();
    do_start();
    atk_b = 8'd50;
    req_b = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin
      failures++;
      $display("FAIL discard_grant: gnt_b=%b, expected 1", gnt_b);
    end
    start = 1'b1;
    req_b = 1'b0;
    @(negedge clk);
    start = 1'b0;
    model_start();
    check_idle_state("discard_now", 8'd100, 8'd100, 8'd0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check_idle_state("discard_later", 8'd100, 8'd100, 8'd0, 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid_apply();
    do_start();
    atk_a = 8'd5;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL apply_busy: busy=%b before reset, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    check_idle_state("async_reset", 8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    check_idle_state("start_after_reset", 8'd100, 8'd100, 8'd0, 2'b00, 1'b0);
  endtask

  initial begin
    model_start();
    test_reset();
    test_single_attack();
    test_ko();
    test_restart_from_over();
    test_round_robin();
    test_zero_attack();
    test_turn_saturate();
    test_start_discard();
    test_reset_mid_apply();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
